// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life grid engine.
//   state_t      : engine FSM states
//   BIRTH_N etc. : B3/S23 rule constants
//   popcount()   : live-cell count of one row, rows up to POP_IN_W cells
package life_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPUTE    = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    localparam int unsigned NBR_W      = 4;
    localparam int unsigned BIRTH_N    = 3;
    localparam int unsigned SURVIVE_LO = 2;
    localparam int unsigned SURVIVE_HI = 3;

    localparam int unsigned POP_IN_W   = 64;
    localparam int unsigned POP_OUT_W  = 7;

    function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
        logic [POP_OUT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(POP_IN_W); i++) begin
            n = n + POP_OUT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Next-generation value of one grid row from the three rows around it.
//   above, cur, below : current-generation rows r-1, r, r+1 (already edge-resolved)
//   next_row          : row r of the next generation
// WRAP selects dead-outside versus toroidal column handling.
module life_row_next
    import life_pkg::*;
#(
    parameter int unsigned COLS = 16,
    parameter int unsigned WRAP = 0
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next_row
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    // Per-column neighbour count over the 3x3 window minus the cell itself.
    always_comb begin
        logic [NBR_W-1:0] cnt;
        int               cc;
        next_row = '0;
        cnt      = '0;
        cc       = 0;
        for (int c = 0; c < int'(COLS); c++) begin
            cnt = '0;
            for (int dc = -1; dc <= 1; dc++) begin
                cc = c + dc;
                if (WRAP != 0) begin
                    if (cc < 0) cc = int'(COLS) - 1;
                    else if (cc >= int'(COLS)) cc = 0;
                end
                if (cc >= 0 && cc < int'(COLS)) begin
                    cnt = cnt + NBR_W'(above[cc[CW-1:0]]) + NBR_W'(below[cc[CW-1:0]]);
                    if (dc != 0) cnt = cnt + NBR_W'(cur[cc[CW-1:0]]);
                end
            end
            if (cur[c]) next_row[c] = (cnt >= NBR_W'(SURVIVE_LO)) && (cnt <= NBR_W'(SURVIVE_HI));
            else        next_row[c] = (cnt == NBR_W'(BIRTH_N));
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Double-buffered Game-of-Life engine: one row per clock into the back bank,
// banks swap only on a frame pulse so the display never sees a partial grid.
//   clk, reset (async, active low)
//   run / step      : free-running level / one-generation request pulse
//   frame           : vertical-blank pulse, the only swap point
//   load_en/row/data: front-bank row write, honoured only while idle
//   rd_row/rd_data  : registered front-bank row read for the display
//   busy, gen_count, population : status of the displayed grid
module life_grid_engine
    import life_pkg::*;
#(
    parameter int unsigned COLS  = 16,
    parameter int unsigned ROWS  = 16,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned GEN_W = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              run,
    input  logic                              step,
    input  logic                              frame,
    input  logic                              load_en,
    input  logic [$clog2(ROWS)-1:0]           load_row,
    input  logic [COLS-1:0]                   load_data,
    input  logic [$clog2(ROWS)-1:0]           rd_row,
    output logic [COLS-1:0]                   rd_data,
    output logic                              busy,
    output logic [GEN_W-1:0]                  gen_count,
    output logic [$clog2(ROWS*COLS+1)-1:0]    population
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned PW = $clog2(ROWS*COLS+1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t          state;
    logic            bank_sel;
    logic            step_pend;
    logic            recount;
    logic [RW-1:0]   r;
    logic [PW-1:0]   acc;
    logic [COLS-1:0] bank [2][ROWS];

    logic [COLS-1:0] above, cur, below, next_row;
    logic [PW-1:0]   grid_pop;
    logic            start;
    logic            swap;
    logic            sel_nxt;

    // Row fetch around r from the front bank, edge rows resolved by WRAP.
    always_comb begin
        cur   = bank[bank_sel][r];
        above = '0;
        below = '0;
        if (r != '0)          above = bank[bank_sel][r - RW'(1)];
        else if (WRAP != 0)   above = bank[bank_sel][LAST_ROW];
        if (r != LAST_ROW)    below = bank[bank_sel][r + RW'(1)];
        else if (WRAP != 0)   below = bank[bank_sel][RW'(0)];
    end

    // Full front-bank recount, used after a load.
    always_comb begin
        grid_pop = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            grid_pop = grid_pop + PW'(popcount(POP_IN_W'(bank[bank_sel][RW'(i)])));
        end
    end

    assign start   = (state == IDLE) && !load_en && (run || step_pend);
    assign swap    = (state == WAIT_FRAME) && frame;
    // Read through the post-swap bank so rd_data follows a swap without a cycle of lag.
    assign sel_nxt = bank_sel ^ swap;

    life_row_next #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_next (
        .above    (above),
        .cur      (cur),
        .below    (below),
        .next_row (next_row)
    );

    // Engine FSM, banks and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bank_sel   <= 1'b0;
            step_pend  <= 1'b0;
            recount    <= 1'b0;
            r          <= '0;
            acc        <= '0;
            rd_data    <= '0;
            busy       <= 1'b0;
            gen_count  <= '0;
            population <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(ROWS); i++) begin
                    bank[b][RW'(i)] <= '0;
                end
            end
        end else begin
            rd_data   <= (rd_row <= LAST_ROW) ? bank[sel_nxt][rd_row] : '0;
            // A step arriving on the start cycle is a fresh request and survives the clear.
            step_pend <= (step_pend && !start) || step;
            recount   <= 1'b0;
            if (recount) population <= grid_pop;

            case (state)
                IDLE: begin
                    if (load_en) begin
                        if (load_row <= LAST_ROW) bank[bank_sel][load_row] <= load_data;
                        recount <= 1'b1;
                    end else if (run || step_pend) begin
                        state <= COMPUTE;
                        r     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    bank[~bank_sel][r] <= next_row;
                    acc <= acc + PW'(popcount(POP_IN_W'(next_row)));
                    if (r == LAST_ROW) begin
                        state <= WAIT_FRAME;
                        r     <= '0;
                    end else begin
                        r <= r + RW'(1);
                    end
                end
                WAIT_FRAME: begin
                    if (frame) begin
                        bank_sel   <= ~bank_sel;
                        gen_count  <= gen_count + GEN_W'(1);
                        population <= acc;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: an 8x8 dead-edge instance and an 8x8 toroidal
// instance share one stimulus stream and are checked against a cell-by-cell
// B3/S23 reference grid per instance.
module tb_life_grid_engine;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned GEN_W = 16;
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned PW    = $clog2(ROWS*COLS+1);
    localparam int          NR    = ROWS;
    localparam int          NC    = COLS;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            run = 1'b0, step = 1'b0, frame = 1'b0, load_en = 1'b0;
    logic [RW-1:0]   load_row = '0;
    logic [COLS-1:0] load_data = '0;
    logic [RW-1:0]   rd_row = '0;

    logic [COLS-1:0] rd_data0, rd_data1;
    logic            busy0, busy1;
    logic [GEN_W-1:0] gen0, gen1;
    logic [PW-1:0]   pop0, pop1;

    int n_assert = 0;
    int n_fail   = 0;
    int gen_exp  = 0;

    bit [COLS-1:0] mg [2][ROWS];
    bit [COLS-1:0] glider [ROWS];

    always #5 clk = ~clk;

    life_grid_engine #(.COLS(COLS), .ROWS(ROWS), .WRAP(0), .GEN_W(GEN_W)) u_dut0 (
        .clk(clk), .reset(reset), .run(run), .step(step), .frame(frame),
        .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .rd_row(rd_row), .rd_data(rd_data0), .busy(busy0),
        .gen_count(gen0), .population(pop0)
    );

    life_grid_engine #(.COLS(COLS), .ROWS(ROWS), .WRAP(1), .GEN_W(GEN_W)) u_dut1 (
        .clk(clk), .reset(reset), .run(run), .step(step), .frame(frame),
        .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .rd_row(rd_row), .rd_data(rd_data1), .busy(busy1),
        .gen_count(gen1), .population(pop1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pop(input int w);
        int n;
        n = 0;
        for (int r = 0; r < NR; r++) n += $countones(mg[w][r]);
        return n;
    endfunction

    // One generation of the reference grid, straight from the neighbour rules.
    task automatic model_step(input int w);
        bit [COLS-1:0] nx [ROWS];
        int n, rr, cc;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0)) begin
                            if (w == 1) begin
                                rr = (rr + NR) % NR;
                                cc = (cc + NC) % NC;
                                n += int'(mg[w][rr][cc]);
                            end else if (rr >= 0 && rr < NR && cc >= 0 && cc < NC) begin
                                n += int'(mg[w][rr][cc]);
                            end
                        end
                    end
                end
                nx[r][c] = (n == 3) || (mg[w][r][c] && n == 2);
            end
        end
        for (int r = 0; r < NR; r++) mg[w][r] = nx[r];
    endtask

    task automatic load_one(input int row, input logic [COLS-1:0] data);
        load_en   = 1'b1;
        load_row  = RW'(row);
        load_data = data;
        tick();
        load_en = 1'b0;
        mg[0][row] = data;
        mg[1][row] = data;
    endtask

    task automatic check_pop(input string tag);
        check({tag, "_pop0"}, 64'(pop0), 64'(model_pop(0)));
        check({tag, "_pop1"}, 64'(pop1), 64'(model_pop(1)));
    endtask

    task automatic read_all();
        for (int r = 0; r < NR; r++) begin
            rd_row = RW'(r);
            tick();
            check($sformatf("row0_%0d", r), 64'(rd_data0), 64'(mg[0][r]));
            check($sformatf("row1_%0d", r), 64'(rd_data1), 64'(mg[1][r]));
        end
    endtask

    task automatic wait_busy();
        int k;
        k = 0;
        while (busy0 !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("start_busy0", 64'(busy0), 64'(1));
        check("start_busy1", 64'(busy1), 64'(1));
    endtask

    // Follows one generation from COMPUTE entry to the swap, optionally
    // poking step/load/frame while computing.
    task automatic do_gen(input bit dbl_step, input bit load_mid, input bit frame_mid,
                          input bit stop_run, input bit rd_all, input int rrow);
        wait_busy();
        if (stop_run) run = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rd_row    = RW'(i);
            step      = dbl_step && (i == 1 || i == 3);
            load_en   = load_mid && (i == 2);
            load_row  = RW'(2);
            load_data = ~mg[0][2];
            frame     = frame_mid && (i == 4);
            tick();
            step = 1'b0; load_en = 1'b0; frame = 1'b0;
            check($sformatf("front0_%0d", i), 64'(rd_data0), 64'(mg[0][i]));
            check($sformatf("front1_%0d", i), 64'(rd_data1), 64'(mg[1][i]));
        end
        check("busy_pre_frame0", 64'(busy0), 64'(1));
        check("busy_pre_frame1", 64'(busy1), 64'(1));
        rd_row = RW'(rrow);
        frame  = 1'b1;
        tick();
        frame = 1'b0;
        model_step(0);
        model_step(1);
        gen_exp++;
        check("gen0", 64'(gen0), 64'(gen_exp % 65536));
        check("gen1", 64'(gen1), 64'(gen_exp % 65536));
        check("busy_post0", 64'(busy0), 64'(0));
        check("busy_post1", 64'(busy1), 64'(0));
        check_pop("gen");
        check("swap_rd0", 64'(rd_data0), 64'(mg[0][rrow]));
        check("swap_rd1", 64'(rd_data1), 64'(mg[1][rrow]));
        if (rd_all) read_all();
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < 2; w++) for (int r = 0; r < NR; r++) mg[w][r] = '0;
        for (int r = 0; r < NR; r++) glider[r] = '0;
        glider[4] = 8'b0010_0000;
        glider[5] = 8'b0100_0000;
        glider[6] = 8'b0111_0000;

        // Reset state
        tick(); tick();
        check("rst_rd0", 64'(rd_data0), 64'(0));
        check("rst_busy0", 64'(busy0), 64'(0));
        check("rst_gen0", 64'(gen0), 64'(0));
        check("rst_pop0", 64'(pop0), 64'(0));
        check("rst_pop1", 64'(pop1), 64'(0));
        reset = 1'b1;
        tick();

        // Vertical blinker, column 4, rows 2..4
        load_one(2, 8'h10);
        load_one(3, 8'h10);
        load_one(4, 8'h10);
        tick();
        check_pop("blinker_load");
        check("blinker_pop_const", 64'(pop0), 64'(3));

        // Step request takes effect one cycle after it is registered
        pulse_step();
        check("step_not_yet0", 64'(busy0), 64'(0));
        do_gen(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        rd_row = RW'(3);
        tick();
        check("blinker_h_row3", 64'(rd_data0), 64'(8'h38));
        check("blinker_h_pop", 64'(pop0), 64'(3));
        check("blinker_h_gen", 64'(gen0), 64'(1));

        // Second generation with a load attempt during COMPUTE
        pulse_step();
        do_gen(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        rd_row = RW'(3);
        tick();
        check("blinker_v_row3", 64'(rd_data0), 64'(8'h10));

        // load_en in IDLE holds off a run start for that cycle
        run = 1'b1;
        load_one(0, 8'h81);
        check("load_blocks0", 64'(busy0), 64'(0));
        tick();
        check("start_after_load0", 64'(busy0), 64'(1));
        check_pop("recount");
        do_gen(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // Two steps during COMPUTE merge into exactly one extra generation
        pulse_step();
        do_gen(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        do_gen(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 15; k++) tick();
        check("no_third_busy", 64'(busy0), 64'(0));
        check("no_third_gen", 64'(gen0), 64'(gen_exp));

        // Random grids, step and run driven
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int r = 0; r < NR; r++) load_one(r, COLS'($urandom));
            tick();
            check_pop("rand_load");
            pulse_step();
            do_gen(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, int'($urandom_range(0, NR - 1)));
            run = 1'b1;
            for (int g = 0; g < 3; g++) begin
                do_gen(1'b0, 1'b0, 1'b0, g == 2, 1'b0, int'($urandom_range(0, NR - 1)));
            end
            read_all();
        end

        // Glider: returns home after 32 generations on the 8x8 torus
        for (int r = 0; r < NR; r++) load_one(r, glider[r]);
        tick();
        check("glider_pop_load", 64'(pop1), 64'(5));
        run = 1'b1;
        for (int g = 0; g < 32; g++) begin
            do_gen(1'b0, 1'b0, 1'b0, g == 31, 1'b0, g % NR);
            check($sformatf("glider_pop5_g%0d", g), 64'(pop1), 64'(5));
        end
        read_all();
        for (int r = 0; r < NR; r++) begin
            rd_row = RW'(r);
            tick();
            check($sformatf("glider_home_%0d", r), 64'(rd_data1), 64'(glider[r]));
        end

        // Asynchronous reset in the middle of COMPUTE (r = 5)
        pulse_step();
        wait_busy();
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b0;
        #1;
        check("arst_busy0", 64'(busy0), 64'(0));
        check("arst_gen0", 64'(gen0), 64'(0));
        check("arst_pop0", 64'(pop0), 64'(0));
        check("arst_rd0", 64'(rd_data0), 64'(0));
        check("arst_gen1", 64'(gen1), 64'(0));
        check("arst_pop1", 64'(pop1), 64'(0));
        tick(); tick();
        reset = 1'b1;
        for (int w = 0; w < 2; w++) for (int r = 0; r < NR; r++) mg[w][r] = '0;
        gen_exp = 0;
        tick();
        pulse_step();
        do_gen(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("empty_pop", 64'(pop0), 64'(0));
        check("empty_gen", 64'(gen0), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
